// File: rtl/keypad_emulator_if.sv
// Request channel between a key-press source (master) and keypad_emulator (slave).
interface keypad_emulator_if;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;

  modport master (output req_valid, output req_key, input req_ready);
  modport slave  (input req_valid, input req_key, output req_ready);
endinterface

// File: rtl/keypad_emulator.sv
// 4x3 matrix-keypad key-side model: presses requested keys against a row-scanning controller.
// Optional contact bounce around each press is enabled by defining KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator #(
  parameter int HOLD_SCANS    = 8,
  parameter int GAP_CYCLES    = 16,
  parameter int BOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  keypad_emulator_if.slave   req,
  input  logic [3:0]         key_row,
  output logic [2:0]         key_col,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [7:0]  HOLD_LAST = (HOLD_SCANS < 1) ? 8'd0 : 8'(HOLD_SCANS - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRESS   = 3'd1,
    ST_GAP     = 3'd2
`ifdef KEYPAD_EMU_BOUNCE_EN
    ,
    ST_BNC_IN  = 3'd3,
    ST_BNC_OUT = 3'd4
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  tgt_row_q, tgt_row_d;
  logic [2:0]  tgt_col_q, tgt_col_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic        code_ok;
  logic        row_hit;
  logic [3:0]  map_row;
  logic [2:0]  map_col;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [7:0] BNC_LAST = 8'(BOUNCE_CYCLES - 1);

  logic [7:0] bnc_cnt_q, bnc_cnt_d;
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci x^8+x^6+x^5+x^4+1, free-running so bounce patterns differ press to press.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
`else
  logic [7:0] unused_bounce_cycles;
  assign unused_bounce_cycles = 8'(BOUNCE_CYCLES);
`endif

  assign req.req_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign accept        = req.req_valid && req.req_ready;
  assign code_ok       = (req.req_key <= 4'd11);
  // A malformed (non-one-hot) row drive never matches a key, as on a real matrix.
  assign row_hit       = $onehot(key_row) && (key_row == tgt_row_q);

  always_comb begin
    map_row = 4'b0000;
    map_col = 3'b000;
    case (req.req_key)
      4'd1, 4'd2, 4'd3:   map_row = 4'b1000;
      4'd4, 4'd5, 4'd6:   map_row = 4'b0100;
      4'd7, 4'd8, 4'd9:   map_row = 4'b0010;
      4'd10, 4'd0, 4'd11: map_row = 4'b0001;
      default:            map_row = 4'b0000;
    endcase
    case (req.req_key)
      4'd1, 4'd4, 4'd7, 4'd10: map_col = 3'b100;
      4'd2, 4'd5, 4'd8, 4'd0:  map_col = 3'b010;
      4'd3, 4'd6, 4'd9, 4'd11: map_col = 3'b001;
      default:                 map_col = 3'b000;
    endcase
  end

  always_comb begin
    key_col = 3'b000;
    if (state_q == ST_PRESS && row_hit) key_col = tgt_col_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
    if ((state_q == ST_BNC_IN || state_q == ST_BNC_OUT) && row_hit)
      key_col = tgt_col_q & {3{lfsr_q[0]}};
`endif
  end

  always_comb begin
    state_d    = state_q;
    tgt_row_d  = tgt_row_q;
    tgt_col_d  = tgt_col_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    bnc_cnt_d  = bnc_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (code_ok) begin
            tgt_row_d  = map_row;
            tgt_col_d  = map_col;
            hold_cnt_d = 8'd0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            bnc_cnt_d  = 8'd0;
            state_d    = ST_BNC_IN;
`else
            state_d    = ST_PRESS;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        // Only scans that actually see the key count toward the hold.
        if (row_hit) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
          if (hold_cnt_q == HOLD_LAST) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            bnc_cnt_d = 8'd0;
            state_d   = ST_BNC_OUT;
`else
            gap_cnt_d = 16'd0;
            state_d   = ST_GAP;
`endif
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BNC_IN: begin
        if (bnc_cnt_q == BNC_LAST) begin
          hold_cnt_d = 8'd0;
          state_d    = ST_PRESS;
        end else begin
          bnc_cnt_d = bnc_cnt_q + 8'd1;
        end
      end
      ST_BNC_OUT: begin
        if (bnc_cnt_q == BNC_LAST) begin
          gap_cnt_d = 16'd0;
          state_d   = ST_GAP;
        end else begin
          bnc_cnt_d = bnc_cnt_q + 8'd1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tgt_row_q  <= 4'b0000;
      tgt_col_q  <= 3'b000;
      hold_cnt_q <= 8'd0;
      gap_cnt_q  <= 16'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bnc_cnt_q  <= 8'd0;
      lfsr_q     <= 8'hA5;
`endif
    end else begin
      state_q    <= state_d;
      tgt_row_q  <= tgt_row_d;
      tgt_col_q  <= tgt_col_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      bnc_cnt_q  <= bnc_cnt_d;
      lfsr_q     <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: rotating one-hot row scanner, vector table and expected-key queue.
`timescale 1ns/1ps
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic       busy, done, err;

  keypad_emulator_if rq();

  keypad_emulator #(.HOLD_SCANS(8), .GAP_CYCLES(16), .BOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rq.slave),
    .key_row (key_row),
    .key_col (key_col),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    bit         bad;
    logic [3:0] row;
    logic [2:0] col;
    int         val;
  } vec_t;

  vec_t tbl [10];
  vec_t exp_q [$];
  int   errors = 0;
  int   checks = 0;

  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'b0000;
  logic [1:0] scan_idx = 2'd0;

  // Scanner: one row per clock, full rotation every 4 clocks, overridable for fault rows.
  initial begin
    key_row = 4'b1000;
    forever begin
      @(posedge clk); #1;
      scan_idx = scan_idx + 2'd1;
      key_row  = force_en ? force_val : (4'b1000 >> scan_idx);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, want);
    end
  endtask

  function automatic int decode(input logic [3:0] r, input logic [2:0] c);
    int ri, ci;
    ri = r[3] ? 0 : r[2] ? 1 : r[1] ? 2 : 3;
    ci = c[2] ? 0 : c[1] ? 1 : 2;
    if (ri < 3) return ri * 3 + ci + 1;
    return (ci == 0) ? 10 : (ci == 1) ? 0 : 11;
  endfunction

  task automatic send(input logic [3:0] k, input bit keep);
    int n;
    n = 0;
    rq.req_valid = 1'b1;
    rq.req_key   = k;
    do begin @(negedge clk); n++; end while (!rq.req_ready && n < 300);
    if (!rq.req_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #2;
    if (!keep) rq.req_valid = 1'b0;
  endtask

  task automatic watch_txn(input string nm);
    vec_t e;
    int hits, gap, badrc, badrdy, val, n;
    bit got;
    hits = 0; gap = 0; badrc = 0; badrdy = 0; val = -1; n = 0; got = 0;
    if (exp_q.size() == 0) begin
      chk({nm, "_queue_empty"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    while (n < 400) begin
      @(negedge clk); n++;
      if (done) begin got = 1; break; end
      if (rq.req_ready) badrdy++;
      if (key_col != 3'b000) begin
        hits++;
        gap = 0;
        val = decode(key_row, key_col);
        if (key_row != e.row || key_col != e.col) badrc++;
      end else if (hits > 0) begin
        gap++;
      end
    end
    chk({nm, "_done_seen"}, int'(got), 1);
    chk({nm, "_row_col"}, badrc, 0);
    chk({nm, "_ready_low"}, badrdy, 0);
    chk({nm, "_value"}, val, e.val);
`ifdef KEYPAD_EMU_BOUNCE_EN
    chk({nm, "_hits_min"}, int'(hits >= 8), 1);
    chk({nm, "_hits_max"}, int'(hits <= 16), 1);
    chk({nm, "_gap_min"}, int'(gap >= 16), 1);
    chk({nm, "_gap_max"}, int'(gap <= 20), 1);
`else
    chk({nm, "_hits"}, hits, 8);
    chk({nm, "_gap"}, gap, 16);
`endif
  endtask

  initial begin
    int e_cnt, c_cnt, r_cnt, d_cnt, n, fbad;
    rq.req_valid = 1'b0;
    rq.req_key   = 4'd0;

    tbl[0] = '{4'd5,  1'b0, 4'b0100, 3'b010, 5};
    tbl[1] = '{4'd11, 1'b0, 4'b0001, 3'b001, 11};
    tbl[2] = '{4'd10, 1'b0, 4'b0001, 3'b100, 10};
    tbl[3] = '{4'd0,  1'b0, 4'b0001, 3'b010, 0};
    tbl[4] = '{4'd9,  1'b0, 4'b0010, 3'b001, 9};
    tbl[5] = '{4'd13, 1'b1, 4'b0000, 3'b000, -1};
    tbl[6] = '{4'd1,  1'b0, 4'b1000, 3'b100, 1};
    tbl[7] = '{4'd12, 1'b1, 4'b0000, 3'b000, -1};
    tbl[8] = '{4'd6,  1'b0, 4'b0100, 3'b001, 6};
    tbl[9] = '{4'd15, 1'b1, 4'b0000, 3'b000, -1};

    #1;
    chk("rst_key_col", int'(key_col), 0);
    chk("rst_req_ready", int'(rq.req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].bad) begin
        e_cnt = 0; c_cnt = 0; r_cnt = 0; d_cnt = 0;
        send(tbl[i].key, 1'b0);
        repeat (6) begin
          @(negedge clk);
          e_cnt += int'(err);
          if (key_col != 3'b000) c_cnt++;
          if (!rq.req_ready) r_cnt++;
          d_cnt += int'(done);
        end
        chk($sformatf("bad%0d_err_pulse", tbl[i].key), e_cnt, 1);
        chk($sformatf("bad%0d_key_col", tbl[i].key), c_cnt, 0);
        chk($sformatf("bad%0d_ready_drop", tbl[i].key), r_cnt, 0);
        chk($sformatf("bad%0d_done", tbl[i].key), d_cnt, 0);
      end else begin
        exp_q.push_back(tbl[i]);
        send(tbl[i].key, 1'b0);
        watch_txn($sformatf("key%0d", tbl[i].key));
        @(negedge clk);
        chk($sformatf("key%0d_done_once", tbl[i].key), int'(done), 0);
        chk($sformatf("key%0d_idle_ready", tbl[i].key), int'(rq.req_ready), 1);
      end
    end

    // Key 1 with a malformed row drive held across the start of the press.
    force_val = 4'b1100;
    force_en  = 1'b1;
    @(posedge clk); #2;
    exp_q.push_back(tbl[6]);
    send(4'd1, 1'b0);
    fbad = 0;
    repeat (12) begin
      @(negedge clk);
      if (key_col != 3'b000) fbad++;
    end
    chk("forced_row_key_col", fbad, 0);
    chk("forced_row_busy", int'(busy), 1);
    force_en = 1'b0;
    watch_txn("key1_after_force");

    // Back-to-back keys 1 then 9 with req_valid held high throughout.
    exp_q.push_back(tbl[6]);
    send(4'd1, 1'b1);
    rq.req_key = 4'd9;
    watch_txn("b2b_key1");
    chk("b2b_ready_at_done", int'(rq.req_ready), 1);
    exp_q.push_back(tbl[4]);
    @(posedge clk); #2;
    rq.req_valid = 1'b0;
    chk("b2b_second_accepted", int'(busy), 1);
    watch_txn("b2b_key9");

    // Reset asserted while the key is being seen on its row.
    @(posedge clk); #2;
    send(4'd5, 1'b0);
    n = 0;
    while (key_col == 3'b000 && n < 100) begin @(negedge clk); n++; end
    chk("midpress_col_seen", int'(key_col != 3'b000), 1);
    rst_n = 1'b0;
    #1;
    chk("midpress_rst_key_col", int'(key_col), 0);
    chk("midpress_rst_ready", int'(rq.req_ready), 1);
    chk("midpress_rst_busy", int'(busy), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    exp_q.push_back(tbl[3]);
    send(4'd0, 1'b0);
    watch_txn("after_rst_key0");

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
